// File: rtl/tone_scheduler.sv
// tone_scheduler: fixed-priority arbiter and sequencer sharing one square-wave tone generator
// between three requesters (alarm siren, keypad beep, status chirp); bit 0 is highest priority.
// Optional feature macro: TONE_PREEMPT_EN. When it is defined, a higher-priority request
// re-grants the generator directly during PLAY.
// Ports:
//   clock_25mhz, reset_n        system clock, asynchronous active-low reset
//   req[2:0]                    level requests
//   half_periodN, durationN     per-source half-period (cycles) and duration (ms)
//   grant[2:0]                  one-hot owner of the generator while in PLAY
//   done[2:0]                   one-cycle pulse when the granted tone completes normally
//   busy                        high in PLAY and GAP
//   audio_out                   square wave, low outside PLAY
module tone_scheduler #(
    parameter int TICKS_PER_MS = 25000,
    parameter int GAP_MS       = 2,
    parameter int HP_W         = 15,
    parameter int DUR_W        = 16
) (
    input  logic             clock_25mhz,
    input  logic             reset_n,
    input  logic [2:0]       req,
    input  logic [HP_W-1:0]  half_period0,
    input  logic [HP_W-1:0]  half_period1,
    input  logic [HP_W-1:0]  half_period2,
    input  logic [DUR_W-1:0] duration0,
    input  logic [DUR_W-1:0] duration1,
    input  logic [DUR_W-1:0] duration2,
    output logic [2:0]       grant,
    output logic [2:0]       done,
    output logic             busy,
    output logic             audio_out
);
    localparam int GAP_T = GAP_MS * TICKS_PER_MS;
    localparam int PW    = TICKS_PER_MS > 1 ? $clog2(TICKS_PER_MS) : 1;
    localparam int GW    = GAP_T > 1 ? $clog2(GAP_T) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_MS - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_T - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_grant, r_done, w_src, w_win, w_hi;
    logic [HP_W-1:0]  r_hp, r_hp_cnt, w_hp_in;
    logic [DUR_W-1:0] r_rem, w_dur_in;
    logic [PW-1:0]    r_pre;
    logic [GW-1:0]    r_gap_cnt;
    logic             r_audio, w_load, w_fin, w_finish, w_drop, w_pre_wrap, w_hp_wrap;

    // Requests strictly above the current owner: subtracting 1 from a one-hot grant
    // yields a mask of all lower indices.
    assign w_hi     = req & (r_grant - 3'd1);
    assign w_src    = (r_state == S_IDLE) ? req : w_hi;
    // Isolate the lowest set bit, i.e. the highest-priority requester.
    assign w_win    = w_src & (~w_src + 3'd1);
    assign w_hp_in  = w_win[0] ? half_period0 : w_win[1] ? half_period1 : half_period2;
    assign w_dur_in = w_win[0] ? duration0 : w_win[1] ? duration1 : duration2;

    assign w_pre_wrap = r_pre == PRE_MAX;
    assign w_hp_wrap  = r_hp_cnt == r_hp - HP_W'(1);
    // A zero duration completes on the first PLAY cycle; otherwise the last ms wrap ends the tone.
    assign w_finish   = (r_rem == '0) || (r_rem == DUR_W'(1) && w_pre_wrap);
    assign w_drop     = (req & r_grant) == 3'd0;

    assign grant     = r_grant;
    assign done      = r_done;
    assign busy      = r_state != S_IDLE;
    assign audio_out = r_audio;

    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Normal completion outranks both an abort and a preemption landing on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req != 3'd0) begin
                    w_state_nxt = S_PLAY;
                    w_load      = 1'b1;
                end
            end
            S_PLAY: begin
                if (w_finish) begin
                    w_state_nxt = S_GAP;
                    w_fin       = 1'b1;
                end
`ifdef TONE_PREEMPT_EN
                else if (w_hi != 3'd0) w_load = 1'b1;
`endif
                else if (w_drop) w_state_nxt = S_GAP;
            end
            S_GAP:   w_state_nxt = (r_gap_cnt == GAP_MAX) ? S_IDLE : S_GAP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_grant   <= '0;
            r_done    <= '0;
            r_hp      <= '0;
            r_rem     <= '0;
            r_hp_cnt  <= '0;
            r_pre     <= '0;
            r_gap_cnt <= '0;
            r_audio   <= 1'b0;
        end else begin
            r_done    <= w_fin ? r_grant : 3'd0;
            r_gap_cnt <= (r_state == S_GAP && w_state_nxt == S_GAP) ? r_gap_cnt + GW'(1) : '0;
            if (w_load) begin
                r_grant  <= w_win;
                r_hp     <= (w_hp_in < HP_W'(2)) ? HP_W'(2) : w_hp_in;
                r_rem    <= w_dur_in;
                r_hp_cnt <= '0;
                r_pre    <= '0;
                r_audio  <= 1'b0;
            end else if (w_state_nxt != S_PLAY) begin
                r_grant  <= '0;
                r_hp_cnt <= '0;
                r_pre    <= '0;
                r_audio  <= 1'b0;
            end else begin
                r_hp_cnt <= w_hp_wrap ? '0 : r_hp_cnt + HP_W'(1);
                r_audio  <= r_audio ^ w_hp_wrap;
                r_pre    <= w_pre_wrap ? '0 : r_pre + PW'(1);
                if (w_pre_wrap && r_rem != '0) r_rem <= r_rem - DUR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: self-checking bench for tone_scheduler (TICKS_PER_MS=10, GAP_MS=2).
module tb_tone_scheduler;
    localparam int T = 10;
    localparam int G = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'd0;
    logic [14:0] hp0 = '0, hp1 = '0, hp2 = '0;
    logic [15:0] d0 = '0, d1 = '0, d2 = '0;
    logic [2:0]  grant, done;
    logic        busy, audio;
    int          checks = 0;
    int          failures = 0;

    tone_scheduler #(.TICKS_PER_MS(T), .GAP_MS(2), .HP_W(15), .DUR_W(16)) dut (
        .clock_25mhz(clk), .reset_n(rst_n), .req(req),
        .half_period0(hp0), .half_period1(hp1), .half_period2(hp2),
        .duration0(d0), .duration1(d1), .duration2(d2),
        .grant(grant), .done(done), .busy(busy), .audio_out(audio)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0] req;
        int h0, h1, h2, u0, u1, u2;
        logic [2:0] win;
        int hpe, play;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [7:0] obs();
        return {grant, done, busy, audio};
    endfunction

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got{grant,done,busy,audio}=%b exp=%b", name, k, act, exp);
        end
    endtask

    // Drives one request set and checks every cycle from the grant edge through the gap.
    task automatic run_txn(input logic [2:0] r, input int a0, input int a1, input int a2,
                           input int b0, input int b1, input int b2,
                           input logic [2:0] win, input int hpe, input int play, input string name);
        logic [7:0] e;
        req = r;
        hp0 = 15'(a0); hp1 = 15'(a1); hp2 = 15'(a2);
        d0 = 16'(b0); d1 = 16'(b1); d2 = 16'(b2);
        for (int k = 0; k <= play + G; k++) begin
            @(posedge clk); #1;
            if (k < play)            e = {win, 3'b000, 1'b1, 1'((k / hpe) % 2)};
            else if (k == play)      e = {3'b000, win, 1'b1, 1'b0};
            else if (k < play + G)   e = 8'b0000_0010;
            else                     e = 8'd0;
            chk(name, k, obs(), e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, {7'd0, busy}, 8'd0);
    endtask

    logic [2:0] r;
    int h[3], u[3], w, hpe, play;

    initial begin
        vecs[0] = '{3'b100, 5, 6, 3, 1, 1, 2, 3'b100, 3, 20};
        vecs[1] = '{3'b111, 4, 6, 3, 1, 2, 2, 3'b001, 4, 10};
        vecs[2] = '{3'b110, 4, 0, 3, 1, 1, 2, 3'b010, 2, 10};
        vecs[3] = '{3'b010, 4, 1, 3, 1, 0, 2, 3'b010, 2, 1};
        vecs[4] = '{3'b101, 7, 1, 3, 3, 0, 2, 3'b001, 7, 30};
        vecs[5] = '{3'b110, 7, 5, 9, 3, 2, 1, 3'b010, 5, 20};

        #12;
        chk("reset_state", 0, obs(), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].req, vecs[i].h0, vecs[i].h1, vecs[i].h2,
                    vecs[i].u0, vecs[i].u1, vecs[i].u2,
                    vecs[i].win, vecs[i].hpe, vecs[i].play, "table");
        req = 3'd0;
        @(posedge clk); #1;

        // Abort: source 1 drops its request after the 15th PLAY edge.
        req = 3'b010; hp1 = 15'd3; d1 = 16'd5;
        for (int k = 0; k <= 15; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_play", 15, obs(), {3'b010, 3'b000, 1'b1, 1'b1});
        req = 3'd0;
        @(posedge clk); #1;
        chk("abort_gap", 16, obs(), 8'b0000_0010);
        for (int k = 17; k <= 35; k++) begin
            @(posedge clk); #1;
            chk("abort_gap", k, obs(), 8'b0000_0010);
        end
        @(posedge clk); #1;
        chk("abort_idle", 36, obs(), 8'd0);

        // Asynchronous reset in the middle of a tone.
        req = 3'b001; hp0 = 15'd3; d0 = 16'd3;
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk); #1;
        end
        chk("rst_pre", 4, obs(), {3'b001, 3'b000, 1'b1, 1'b1});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 0, obs(), 8'd0);
        req = 3'b100;
        @(posedge clk); #1;
        chk("rst_hold", 1, obs(), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(3'b100, 3, 3, 3, 3, 3, 1, 3'b100, 3, 10, "rst_regrant");

        // Higher-priority request arriving while source 2 plays.
        req = 3'b100; hp2 = 15'd3; d2 = 16'd3; hp0 = 15'd4; d0 = 16'd1;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        chk("pre_play", 5, obs(), {3'b100, 3'b000, 1'b1, 1'b1});
        req = 3'b101;
        @(posedge clk); #1;
`ifdef TONE_PREEMPT_EN
        chk("preempt", 6, obs(), {3'b001, 3'b000, 1'b1, 1'b0});
        req = 3'd0;
`else
        chk("no_preempt", 6, obs(), {3'b100, 3'b000, 1'b1, 1'b0});
        for (int k = 7; k <= 29; k++) begin
            @(posedge clk); #1;
        end
        chk("no_preempt_hold", 29, obs(), {3'b100, 3'b000, 1'b1, 1'b1});
        @(posedge clk); #1;
        chk("no_preempt_done", 30, obs(), {3'b000, 3'b100, 1'b1, 1'b0});
        req = 3'd0;
`endif
        wait_idle("preempt_idle");

        // Random transactions against a first-set-bit / arithmetic reference model.
        for (int t = 0; t < 30; t++) begin
            r = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                h[i] = int'($urandom_range(0, 6));
                u[i] = int'($urandom_range(0, 3));
            end
            w = 0;
            while (!r[w]) w++;
            hpe  = h[w] < 2 ? 2 : h[w];
            play = u[w] == 0 ? 1 : u[w] * T;
            run_txn(r, h[0], h[1], h[2], u[0], u[1], u[2], 3'(1 << w), hpe, play, "rand");
        end
        req = 3'd0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
Arbiter and sequencer that shares one square-wave tone generator between three requesters: alarm siren, keypad beep and status chirp.
Each requester supplies a half-period in clock cycles and a duration in milliseconds. The block grants the generator by fixed priority, plays the tone for the requested time, inserts a silent gap, then returns to idle.
It sits between the control FSMs and the speaker pin, replacing direct per-source audio muxing.

Parameters:
TICKS_PER_MS, 25000, clock cycles per millisecond tick (bench overrides to a small value)
GAP_MS, 2, silent milliseconds inserted after every tone, whether completed or aborted
HP_W, 15, width of the half-period inputs
DUR_W, 16, width of the duration inputs

Ports:
clock_25mhz  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  3  level request per source; bit 0 is highest priority
half_period0  in  HP_W  source 0 half-period in cycles
half_period1  in  HP_W  source 1 half-period in cycles
half_period2  in  HP_W  source 2 half-period in cycles
duration0  in  DUR_W  source 0 duration in ms
duration1  in  DUR_W  source 1 duration in ms
duration2  in  DUR_W  source 2 duration in ms
grant  out  3  one-hot; marks the source currently owning the generator
done  out  3  one-cycle pulse when the granted tone completes normally
busy  out  1  high in PLAY and GAP
audio_out  out  1  square wave; low whenever not in PLAY

Behaviour:
- Reset is asynchronous: reset_n low forces state IDLE and clears grant, done, busy, audio_out, all counters and all latched values.
- Reset mid-tone aborts the tone. No done pulse is issued for it.
- States:
  - IDLE: all outputs low.
  - PLAY: grant one-hot, busy high, audio toggling.
  - GAP: grant 0, busy high, audio_out 0.
- IDLE -> PLAY:
  - Arbitration happens on any edge where req != 0; the lowest set index wins.
  - On that same edge: grant is set, the winner's half_period and duration are latched, the ms prescaler and half-period counter clear, and audio_reg clears.
  - Later changes on the latched inputs are ignored until the next grant.
- Latched half-period below 2 is clamped to 2.
- Tone generation in PLAY:
  - Counter runs 0..hp-1.
  - At hp-1: audio_reg toggles and the counter returns to 0.
  - First toggle occurs hp cycles after entering PLAY; the output period is 2*hp cycles.
- Duration timing in PLAY:
  - The prescaler counts 0..TICKS_PER_MS-1.
  - Each wrap decrements the remaining-ms count.
  - When remaining is 1 and the prescaler wraps, that edge pulses done for the granted bit and moves to GAP.
- Latched duration 0: the first PLAY cycle pulses done and moves to GAP. audio_out never goes high.
- Abort: if the granted source's req bit drops during PLAY, the next edge moves to GAP with no done pulse. If done and the req drop land on the same edge, done wins.
- GAP: lasts GAP_MS*TICKS_PER_MS cycles, then returns to IDLE. Arbitration resumes in IDLE on the following edge.
- A requester holding req after done is re-granted after the gap. Lower-priority sources can starve; this is accepted by design.
- Remaining-ms is DUR_W wide and never underflows. Counters are only as wide as their parameters require.

Optional Feature:
TONE_PREEMPT_EN
- Defined: during PLAY, if a higher-priority req bit (lower index than the granted one) is high, the next edge re-grants to it directly.
  - The preempted source gets no done pulse; there is no GAP.
  - New half_period and duration are latched, counters clear, and audio_reg clears.
  - Lower- or equal-priority requests never preempt.
- Undefined: PLAY is non-preemptive; higher-priority requests wait for GAP -> IDLE.

Test Plan (TICKS_PER_MS=10, GAP_MS=2):
- Single request: req=3'b100, hp2=3, dur2=2.
  - grant=3'b100 the edge after req.
  - audio toggles every 3 cycles.
  - done[2] pulses exactly 20 cycles after grant rises.
  - busy stays high for a further 20 gap cycles, then drops.
- Simultaneous requests: req=3'b111.
  - grant=3'b001 first.
  - After done[0] and the gap, with req still 3'b110, grant=3'b010.
- Abort: source 1 granted with dur=5; req[1] drops at cycle 15.
  - GAP is entered next edge; done stays 0; audio_out=0.
  - IDLE is reached 20 cycles later.
- Edge values:
  - hp=0 gives a period of 4 cycles.
  - dur=0 gives a done pulse on the first PLAY cycle, audio never high, then a normal gap.
- Async reset: assert reset_n low mid-PLAY, between clock edges.
  - grant, busy and audio_out go to 0 immediately.
  - No done pulse.
  - After release, IDLE re-arbitrates from the current req.
- Preemption (TONE_PREEMPT_EN): source 2 playing, req[0] rises.
  - Next edge: grant=3'b001, done[2]=0, busy stays high.
  - Without the macro, grant stays 3'b100 until done[2].
